r4_bfly_stage: RTL and testbench

//  Radix-4 DIF butterfly plus twiddle multiply for the 16-point FFT. Sits directly

---
 rtl/r4_bfly_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_r4_bfly_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_bfly_stage.sv
// r4_bfly_stage
//   Radix-4 DIF butterfly followed by a W16^(g*m) twiddle multiply for the
//   16-point FFT. A frame is four groups of four complex samples; each group
//   is captured, butterflied, twiddled, rounded/saturated and presented four
//   cycles after capture, in the same group order it arrived in.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   data_in_1     input group {x3,x2,x1,x0}, each xi = {re[DW-1:0], im[DW-1:0]}
//   s_p_flag_in   1-cycle pulse; group 0 is on data_in_1 in the following cycle
//   data_out_1    output group {y3,y2,y1,y0}, same packing as the input
//   bf_valid_out  high while data_out_1 holds a valid group
//   bf_flag_out   1-cycle pulse, one cycle before output group 0
//   bf_err_out    1-cycle pulse after a flag arrives while groups 0-2 are captured
module r4_bfly_stage #(
    parameter int DW    = 17,
    parameter bit TW_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8*DW-1:0] data_in_1,
    input  logic            s_p_flag_in,
    output logic [8*DW-1:0] data_out_1,
    output logic            bf_valid_out,
    output logic            bf_flag_out,
    output logic            bf_err_out
);
    localparam int PW = DW + 16;   // one real product
    localparam int SW = DW + 17;   // sum of two real products

    // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q1.15, +1.0 held as 32767.
    localparam logic signed [15:0] W_RE [16] = '{
        16'sd32767,  16'sd30274,  16'sd23170,  16'sd12540,
        16'sd0,     -16'sd12540, -16'sd23170, -16'sd30274,
        16'sh8000,  -16'sd30274, -16'sd23170, -16'sd12540,
        16'sd0,      16'sd12540,  16'sd23170,  16'sd30274};
    localparam logic signed [15:0] W_IM [16] = '{
        16'sd0,     -16'sd12540, -16'sd23170, -16'sd30274,
        16'sh8000,  -16'sd30274, -16'sd23170, -16'sd12540,
        16'sd0,      16'sd12540,  16'sd23170,  16'sd30274,
        16'sd32767,  16'sd30274,  16'sd23170,  16'sd12540};

    // Clamp a DW+2 bit value into the DW-bit two's complement range.
    function automatic logic [DW-1:0] sat(input logic [DW+1:0] v);
        if (v[DW+1:DW-1] == 3'b000 || v[DW+1:DW-1] == 3'b111)
            sat = v[DW-1:0];
        else if (v[DW+1])
            sat = {1'b1, {(DW-1){1'b0}}};
        else
            sat = {1'b0, {(DW-1){1'b1}}};
    endfunction

    // ---------------- capture FSM ----------------
    typedef enum logic {IDLE, RUN} state_t;
    state_t     state_reg, state_next;
    logic [1:0] g_reg, g_next;
    logic       err_next;
    logic       capture;

    assign capture = (state_reg == RUN);

    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_p_flag_in) begin
                    state_next = RUN;
                    g_next     = 2'd0;
                end
            end
            RUN: begin
                if (g_reg == 2'd3) begin
                    // A flag on the last group starts the next frame with no gap.
                    g_next     = 2'd0;
                    state_next = s_p_flag_in ? RUN : IDLE;
                end else begin
                    g_next   = g_reg + 2'd1;
                    err_next = s_p_flag_in;
                end
            end
            default: begin
                state_next = IDLE;
                g_next     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            g_reg      <= 2'd0;
            bf_err_out <= 1'b0;
        end else begin
            state_reg  <= state_next;
            g_reg      <= g_next;
            bf_err_out <= err_next;
        end
    end

    // ---------------- P1 input register ----------------
    logic            p1_valid_reg;
    logic [1:0]      p1_g_reg;
    logic [8*DW-1:0] p1_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_reg <= 1'b0;
            p1_g_reg     <= 2'd0;
            p1_data_reg  <= '0;
        end else begin
            p1_valid_reg <= capture;
            if (capture) begin
                p1_g_reg    <= g_reg;
                p1_data_reg <= data_in_1;
            end
        end
    end

    // ---------------- butterfly (full precision) ----------------
    logic signed [DW+1:0] x_re [4];
    logic signed [DW+1:0] x_im [4];
    logic signed [DW+1:0] b_re [4];
    logic signed [DW+1:0] b_im [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x_re[i] = {{2{p1_data_reg[i*2*DW+2*DW-1]}}, p1_data_reg[i*2*DW+DW +: DW]};
            x_im[i] = {{2{p1_data_reg[i*2*DW+DW-1]}},   p1_data_reg[i*2*DW +: DW]};
        end
        // Multiplying by +/-j is done by swapping re/im and negating one side.
        b_re[0] = x_re[0] + x_re[1] + x_re[2] + x_re[3];
        b_im[0] = x_im[0] + x_im[1] + x_im[2] + x_im[3];
        b_re[1] = x_re[0] + x_im[1] - x_re[2] - x_im[3];
        b_im[1] = x_im[0] - x_re[1] - x_im[2] + x_re[3];
        b_re[2] = x_re[0] - x_re[1] + x_re[2] - x_re[3];
        b_im[2] = x_im[0] - x_im[1] + x_im[2] - x_im[3];
        b_re[3] = x_re[0] - x_im[1] - x_re[2] + x_im[3];
        b_im[3] = x_im[0] + x_re[1] - x_im[2] - x_re[3];
    end

    // ---------------- shared pipeline control ----------------
    logic       p2_valid_reg;
    logic       p3_valid_reg;
    logic [1:0] p2_g_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_valid_reg <= 1'b0;
            p3_valid_reg <= 1'b0;
            p2_g_reg     <= 2'd0;
            bf_valid_out <= 1'b0;
            bf_flag_out  <= 1'b0;
        end else begin
            p2_valid_reg <= p1_valid_reg;
            p3_valid_reg <= p2_valid_reg;
            bf_valid_out <= p3_valid_reg;
            // Group 0 sitting in P2 reaches the output two cycles later.
            bf_flag_out  <= p2_valid_reg && (p2_g_reg == 2'd0);
            if (p1_valid_reg)
                p2_g_reg <= p1_g_reg;
        end
    end

    // ---------------- per-output lanes: P2 scale, P3 multiply, P4 round/sat ----
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [3:0] LANE = 4'(gi);

            logic signed [DW-1:0] p2_re_reg, p2_im_reg;
            logic [3:0]           tw_idx;
            logic signed [15:0]   w_re, w_im;
            logic                 bypass;
            logic signed [PW-1:0] a_ext, b_ext, c_ext, d_ext;
            logic signed [PW-1:0] ac, bd, ad, bc;
            logic signed [SW-1:0] re_next, im_next;
            logic signed [SW-1:0] p3_re_reg, p3_im_reg;
            logic signed [SW-1:0] re_rnd, im_rnd;
            logic [DW-1:0]        p4_re_reg, p4_im_reg;

            assign tw_idx = {2'b00, p2_g_reg} * LANE;
            assign w_re   = W_RE[tw_idx];
            assign w_im   = W_IM[tw_idx];
            assign bypass = !TW_EN || (tw_idx == 4'd0);

            assign a_ext = {{(PW-DW){p2_re_reg[DW-1]}}, p2_re_reg};
            assign b_ext = {{(PW-DW){p2_im_reg[DW-1]}}, p2_im_reg};
            assign c_ext = {{(PW-16){w_re[15]}}, w_re};
            assign d_ext = {{(PW-16){w_im[15]}}, w_im};
            assign ac = a_ext * c_ext;
            assign bd = b_ext * d_ext;
            assign ad = a_ext * d_ext;
            assign bc = b_ext * c_ext;

            // Bypass pre-shifts by 15 so the common rounding step returns it exactly.
            assign re_next = bypass ? {{2{p2_re_reg[DW-1]}}, p2_re_reg, 15'd0}
                                    : ({ac[PW-1], ac} - {bd[PW-1], bd});
            assign im_next = bypass ? {{2{p2_im_reg[DW-1]}}, p2_im_reg, 15'd0}
                                    : ({ad[PW-1], ad} + {bc[PW-1], bc});

            assign re_rnd = p3_re_reg + {{(SW-15){1'b0}}, 1'b1, 14'd0};
            assign im_rnd = p3_im_reg + {{(SW-15){1'b0}}, 1'b1, 14'd0};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p2_re_reg <= '0;
                    p2_im_reg <= '0;
                    p3_re_reg <= '0;
                    p3_im_reg <= '0;
                    p4_re_reg <= '0;
                    p4_im_reg <= '0;
                end else begin
                    if (p1_valid_reg) begin
                        // Arithmetic shift right by 2 is the bit slice [DW+1:2].
                        p2_re_reg <= b_re[gi][DW+1:2];
                        p2_im_reg <= b_im[gi][DW+1:2];
                    end
                    if (p2_valid_reg) begin
                        p3_re_reg <= re_next;
                        p3_im_reg <= im_next;
                    end
                    if (p3_valid_reg) begin
                        p4_re_reg <= sat(re_rnd[SW-1:15]);
                        p4_im_reg <= sat(im_rnd[SW-1:15]);
                    end
                end
            end

            assign data_out_1[gi*2*DW +: 2*DW] = {p4_re_reg, p4_im_reg};
        end
    endgenerate

endmodule

// File: tb/tb_r4_bfly_stage.sv
module tb_r4_bfly_stage;
    localparam real PI = 3.14159265358979323846;

    logic         clk;
    logic         rst_n;
    logic [135:0] data_in_1;
    logic         s_p_flag_in;
    logic [135:0] data_tw, data_bp;
    logic         valid_tw, valid_bp, flag_tw, flag_bp, err_tw, err_bp;

    r4_bfly_stage #(.DW(17), .TW_EN(1'b1)) dut_tw (
        .clk(clk), .rst_n(rst_n), .data_in_1(data_in_1), .s_p_flag_in(s_p_flag_in),
        .data_out_1(data_tw), .bf_valid_out(valid_tw), .bf_flag_out(flag_tw),
        .bf_err_out(err_tw));

    r4_bfly_stage #(.DW(17), .TW_EN(1'b0)) dut_bp (
        .clk(clk), .rst_n(rst_n), .data_in_1(data_in_1), .s_p_flag_in(s_p_flag_in),
        .data_out_1(data_bp), .bf_valid_out(valid_bp), .bf_flag_out(flag_bp),
        .bf_err_out(err_bp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [135:0] data;
        logic [1:0]   g;
        int           cyc;
    } exp_t;

    exp_t q_tw[$];
    exp_t q_bp[$];
    int   total = 0;
    int   bad = 0;
    int   err_exp = 0;
    int   err_seen_tw = 0;
    int   err_seen_bp = 0;
    logic prev_flag_tw = 1'b0;
    logic prev_flag_bp = 1'b0;

    int fr_re [4][4];   // [group][sample]
    int fr_im [4][4];

    // ---------------- reference model ----------------
    function automatic longint q15(input real v);
        longint t;
        t = longint'($floor(v * 32768.0 + 0.5));
        if (t > 32767) t = 32767;
        return t;
    endfunction

    function automatic longint clamp17(input longint v);
        if (v > 65535) return 65535;
        if (v < -65536) return -65536;
        return v;
    endfunction

    // 4-point DFT, /4 with floor, then optional W16^(g*m) with round half up.
    function automatic logic [135:0] model_group(input int g, input bit tw_on);
        logic [135:0] r;
        longint yr, yi, wr, wi, pr, pim;
        int k;
        r = '0;
        for (int m = 0; m < 4; m++) begin
            yr = 0;
            yi = 0;
            for (int n = 0; n < 4; n++) begin
                case ((n * m) % 4)
                    0: begin yr += fr_re[g][n]; yi += fr_im[g][n]; end
                    1: begin yr += fr_im[g][n]; yi -= fr_re[g][n]; end
                    2: begin yr -= fr_re[g][n]; yi -= fr_im[g][n]; end
                    default: begin yr -= fr_im[g][n]; yi += fr_re[g][n]; end
                endcase
            end
            yr = yr >>> 2;
            yi = yi >>> 2;
            k = (g * m) % 16;
            if (tw_on && k != 0) begin
                wr  = q15($cos(2.0 * PI * k / 16.0));
                wi  = q15(-$sin(2.0 * PI * k / 16.0));
                pr  = yr * wr - yi * wi;
                pim = yr * wi + yi * wr;
                yr  = clamp17((pr + 16384) >>> 15);
                yi  = clamp17((pim + 16384) >>> 15);
            end
            r[m*34 +: 34] = {yr[16:0], yi[16:0]};
        end
        return r;
    endfunction

    function automatic logic [135:0] pack_group(input int g);
        logic [135:0] d;
        logic [16:0]  re, im;
        for (int n = 0; n < 4; n++) begin
            re = 17'(fr_re[g][n]);
            im = 17'(fr_im[g][n]);
            d[n*34 +: 34] = {re, im};
        end
        return d;
    endfunction

    function automatic int rnd17();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    task automatic fill_const(input int re, input int im);
        for (int g = 0; g < 4; g++)
            for (int n = 0; n < 4; n++) begin
                fr_re[g][n] = re;
                fr_im[g][n] = im;
            end
    endtask

    task automatic fill_impulse();
        fill_const(0, 0);
        for (int g = 0; g < 4; g++) fr_re[g][0] = 4000;
    endtask

    // Drives y2 to (-65536,-65536) so the 45/90/135 degree twiddles overflow.
    task automatic fill_sat();
        for (int g = 0; g < 4; g++)
            for (int n = 0; n < 4; n++) begin
                fr_re[g][n] = (n % 2 == 0) ? -65536 : 65535;
                fr_im[g][n] = (n % 2 == 0) ? -65536 : 65535;
            end
    endtask

    task automatic fill_random();
        for (int g = 0; g < 4; g++)
            for (int n = 0; n < 4; n++) begin
                fr_re[g][n] = rnd17();
                fr_im[g][n] = rnd17();
            end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_cycle(input logic flag, input logic [135:0] d);
        @(posedge clk);
        #1;
        s_p_flag_in = flag;
        data_in_1   = d;
    endtask

    function automatic logic [135:0] junk();
        return {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, junk());
    endtask

    task automatic send_frame(input bit lead_flag, input bit err_at_g1, input bit flag_at_g3);
        exp_t e;
        if (lead_flag) drive_cycle(1'b1, junk());
        for (int g = 0; g < 4; g++) begin
            drive_cycle((g == 1 && err_at_g1) || (g == 3 && flag_at_g3), pack_group(g));
            if (g == 1 && err_at_g1) err_exp++;
            e.g    = 2'(g);
            e.cyc  = cyc + 4;
            e.data = model_group(g, 1'b1);
            q_tw.push_back(e);
            e.data = model_group(g, 1'b0);
            q_bp.push_back(e);
        end
    endtask

    task automatic check_eq(input string name, input logic [135:0] got, input logic [135:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check_port(input int id, input logic valid, input logic pflag,
                              input logic [135:0] d);
        exp_t e;
        int   qsize;
        string tag;
        tag = (id == 0) ? "tw" : "bp";
        if (!valid) begin
            if (pflag) begin
                total++;
                bad++;
                $display("FAIL flag_without_group dut=%s cyc=%0d got_valid=0 want_valid=1", tag, cyc);
            end
            return;
        end
        qsize = (id == 0) ? q_tw.size() : q_bp.size();
        total++;
        if (qsize == 0) begin
            bad++;
            $display("FAIL unexpected_valid dut=%s cyc=%0d got=%h want=no_output", tag, cyc, d);
            return;
        end
        if (id == 0) e = q_tw.pop_front();
        else         e = q_bp.pop_front();
        if (d !== e.data) begin
            bad++;
            $display("FAIL data dut=%s grp=%0d got=%h want=%h", tag, e.g, d, e.data);
        end
        total++;
        if (cyc != e.cyc) begin
            bad++;
            $display("FAIL latency dut=%s grp=%0d got_cyc=%0d want_cyc=%0d", tag, e.g, cyc, e.cyc);
        end
        total++;
        if (pflag !== (e.g == 2'd0)) begin
            bad++;
            $display("FAIL flag_timing dut=%s grp=%0d got_prev_flag=%0b want=%0b", tag, e.g, pflag, e.g == 2'd0);
        end
        $display("out dut=%s grp=%0d cyc=%0d data=%h", tag, e.g, cyc, d);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_port(0, valid_tw, prev_flag_tw, data_tw);
            check_port(1, valid_bp, prev_flag_bp, data_bp);
            if (err_tw) err_seen_tw++;
            if (err_bp) err_seen_bp++;
        end
        prev_flag_tw = flag_tw;
        prev_flag_bp = flag_bp;
    end

    task automatic check_outputs_zero(input string phase);
        check_eq({phase, "_data_tw"}, data_tw, 136'd0);
        check_eq({phase, "_data_bp"}, data_bp, 136'd0);
        check_eq({phase, "_ctl_tw"}, {133'd0, valid_tw, flag_tw, err_tw}, 136'd0);
        check_eq({phase, "_ctl_bp"}, {133'd0, valid_bp, flag_bp, err_bp}, 136'd0);
    endtask

    task automatic check_err_counts();
        check_eq("err_count_tw", 136'(err_seen_tw), 136'(err_exp));
        check_eq("err_count_bp", 136'(err_seen_bp), 136'(err_exp));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n       = 1'b0;
        s_p_flag_in = 1'b0;
        data_in_1   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(3);

        fill_const(1000, 0);
        send_frame(1'b1, 1'b0, 1'b0);
        idle(6);

        fill_impulse();
        send_frame(1'b1, 1'b0, 1'b0);
        idle(6);

        fill_const(65535, 65535);
        send_frame(1'b1, 1'b0, 1'b0);
        idle(2);
        fill_sat();
        send_frame(1'b1, 1'b0, 1'b0);
        idle(6);

        // Three frames on a 16-cycle flag period.
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(1'b1, 1'b0, 1'b0);
            idle(11);
        end

        // Back-to-back frames: the next flag rides on group 3.
        fill_random();
        send_frame(1'b1, 1'b0, 1'b1);
        fill_random();
        send_frame(1'b0, 1'b0, 1'b1);
        fill_random();
        send_frame(1'b0, 1'b0, 1'b0);
        idle(6);
        check_err_counts();

        // Stray flag during group 1: ignored, error pulse, frame completes.
        fill_random();
        send_frame(1'b1, 1'b1, 1'b0);
        idle(6);
        check_err_counts();

        for (int f = 0; f < 6; f++) begin
            fill_random();
            send_frame(1'b1, 1'b0, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(6);

        // Reset while a frame is half captured and the previous one is still emerging.
        fill_random();
        send_frame(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, junk());
        drive_cycle(1'b0, pack_group(0));
        drive_cycle(1'b0, pack_group(1));
        drive_cycle(1'b0, junk());
        #1;
        rst_n = 1'b0;
        q_tw.delete();
        q_bp.delete();
        #1;
        check_outputs_zero("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(12);

        fill_random();
        send_frame(1'b1, 1'b0, 1'b0);
        idle(8);

        check_eq("leftover_tw", 136'(q_tw.size()), 136'd0);
        check_eq("leftover_bp", 136'(q_bp.size()), 136'd0);
        check_err_counts();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
